// File: rtl/hazard_scoreboard.sv
// Issue controller between decode and execute: RAW/WAW scoreboard, divider
// occupancy tracking, branch squash of the youngest issued op, and stall counting.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int DIV_LATENCY = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_valid,
    input  logic [4:0]           dec_rs1,
    input  logic                 dec_rs1_used,
    input  logic [4:0]           dec_rs2,
    input  logic                 dec_rs2_used,
    input  logic [4:0]           dec_rd,
    input  logic                 dec_rd_write,
    input  logic                 dec_multicycle,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic                 branch_taken,
    output logic                 issue,
    output logic                 stall,
    output logic                 flush,
    output logic                 div_busy,
    output logic [NUM_REGS-1:0]  pending,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int DCW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [DCW-1:0] DIV_LOAD = DCW'(DIV_LATENCY - 1);
    localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic {S_IDLE, S_BUSY} div_state_t;

    div_state_t           r_state;
    logic [DCW-1:0]       r_div_cnt;
    logic                 r_div_busy;
    logic [NUM_REGS-1:0]  r_pending;
    logic [CNT_WIDTH-1:0] r_stall_count;
    logic [4:0]           r_last_rd;
    logic                 r_last_rd_valid;
    logic                 r_last_mc;

    logic [NUM_REGS-1:0]  w_wbmask;
    logic [NUM_REGS-1:0]  w_eff;
    logic [NUM_REGS-1:0]  w_pending_nxt;
    logic                 w_raw;
    logic                 w_issue;
    logic                 w_stall;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    // A register retiring this cycle is already visible to decode (write-before-read).
    always_comb begin
        w_wbmask = '0;
        if (wb_valid) w_wbmask[wb_rd] = 1'b1;
        w_eff = r_pending & ~w_wbmask;

        w_raw = (dec_rs1_used && dec_rs1 != 5'd0 && w_eff[dec_rs1]) ||
                (dec_rs2_used && dec_rs2 != 5'd0 && w_eff[dec_rs2]) ||
                (dec_rd_write && dec_rd  != 5'd0 && w_eff[dec_rd]);

        w_issue = dec_valid && !w_raw && !r_div_busy && !branch_taken;
        w_stall = dec_valid && !w_issue && !branch_taken;

        // Squash clears the op in ID/EX; a fresh issue to the same index wins.
        w_pending_nxt = w_eff;
        if (branch_taken && r_last_rd_valid) w_pending_nxt[r_last_rd] = 1'b0;
        if (w_issue && dec_rd_write && dec_rd != 5'd0) w_pending_nxt[dec_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    assign issue       = w_issue;
    assign stall       = w_stall;
    assign flush       = branch_taken;
    assign div_busy    = r_div_busy;
    assign pending     = r_pending;
    assign stall_count = r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending       <= '0;
            r_stall_count   <= '0;
            r_last_rd       <= '0;
            r_last_rd_valid <= 1'b0;
            r_last_mc       <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_stall) r_stall_count <= sat_inc(r_stall_count);
            if (w_issue) begin
                r_last_rd       <= dec_rd;
                r_last_rd_valid <= dec_rd_write && (dec_rd != 5'd0);
                r_last_mc       <= dec_multicycle;
            end else begin
                r_last_rd       <= '0;
                r_last_rd_valid <= 1'b0;
                r_last_mc       <= 1'b0;
            end
        end
    end

    // Divider occupancy: busy for exactly DIV_LATENCY cycles after issue,
    // cut short if the divide itself is squashed by a taken branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_div_busy <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue && dec_multicycle) begin
                        r_state    <= S_BUSY;
                        r_div_cnt  <= DIV_LOAD;
                        r_div_busy <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (branch_taken && r_last_mc) begin
                        r_state    <= S_IDLE;
                        r_div_cnt  <= '0;
                        r_div_busy <= 1'b0;
                    end else if (r_div_cnt == '0) begin
                        r_state    <= S_IDLE;
                        r_div_busy <= 1'b0;
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_ONE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_div_cnt  <= '0;
                    r_div_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one task per scenario, hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic        dec_rs1_used;
    logic [4:0]  dec_rs2;
    logic        dec_rs2_used;
    logic [4:0]  dec_rd;
    logic        dec_rd_write;
    logic        dec_multicycle;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        branch_taken;
    logic        issue;
    logic        stall;
    logic        flush;
    logic        div_busy;
    logic [31:0] pending;
    logic [31:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    hazard_scoreboard #(.NUM_REGS(32), .DIV_LATENCY(8), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
        .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd), .dec_rd_write(dec_rd_write),
        .dec_multicycle(dec_multicycle),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .branch_taken(branch_taken),
        .issue(issue), .stall(stall), .flush(flush), .div_busy(div_busy),
        .pending(pending), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_rs1 = 0; dec_rs1_used = 0; dec_rs2 = 0; dec_rs2_used = 0;
        dec_rd = 0; dec_rd_write = 0; dec_multicycle = 0;
        wb_valid = 0; wb_rd = 0; branch_taken = 0;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic rs1u, input logic [4:0] rs2,
                         input logic rs2u, input logic [4:0] rd, input logic rdw, input logic mc);
        dec_valid = 1; dec_rs1 = rs1; dec_rs1_used = rs1u; dec_rs2 = rs2; dec_rs2_used = rs2u;
        dec_rd = rd; dec_rd_write = rdw; dec_multicycle = mc;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL reset_pending got %h exp %h", pending, 32'h0); end
        n_vec++; if (div_busy !== 1'b0) begin n_err++; $display("FAIL reset_div_busy got %b exp 0", div_busy); end
        n_vec++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL reset_stall_count got %0d exp 0", stall_count); end
        n_vec++; if (issue !== 1'b0) begin n_err++; $display("FAIL reset_issue got %b exp 0", issue); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall); end
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b exp 0", flush); end
    endtask

    task automatic test_raw();
        drive(5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
        settle();
        n_vec++; if (issue !== 1'b1) begin n_err++; $display("FAIL raw_addi_issue got %b exp 1", issue); end
        step();
        n_vec++; if (pending !== 32'h20) begin n_err++; $display("FAIL raw_set5 got %h exp %h", pending, 32'h20); end
        drive(5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        for (int i = 0; i < 2; i++) begin
            settle();
            n_vec++; if (stall !== 1'b1 || issue !== 1'b0) begin n_err++; $display("FAIL raw_stall_%0d got stall=%b issue=%b exp stall=1 issue=0", i, stall, issue); end
            step();
        end
        wb_valid = 1; wb_rd = 5'd5;
        settle();
        n_vec++; if (issue !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL raw_wb_issue got issue=%b stall=%b exp issue=1 stall=0", issue, stall); end
        step();
        idle_inputs();
        n_vec++; if (pending !== 32'h40) begin n_err++; $display("FAIL raw_pending_after got %h exp %h", pending, 32'h40); end
        n_vec++; if (stall_count !== 32'd2) begin n_err++; $display("FAIL raw_stall_count got %0d exp 2", stall_count); end
        wb_valid = 1; wb_rd = 5'd6;
        step();
        idle_inputs();
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL raw_wb6_clear got %h exp 0", pending); end
    endtask

    task automatic test_div_struct();
        do_reset();
        drive(5'd1, 1, 5'd2, 1, 5'd7, 1, 1);
        settle();
        n_vec++; if (issue !== 1'b1 || div_busy !== 1'b0) begin n_err++; $display("FAIL div_issue got issue=%b busy=%b exp issue=1 busy=0", issue, div_busy); end
        step();
        n_vec++; if (pending !== 32'h80) begin n_err++; $display("FAIL div_pend7 got %h exp %h", pending, 32'h80); end
        drive(5'd1, 1, 5'd2, 1, 5'd8, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            settle();
            n_vec++; if (div_busy !== 1'b1 || stall !== 1'b1) begin n_err++; $display("FAIL div_busy_T%0d got busy=%b stall=%b exp busy=1 stall=1", i, div_busy, stall); end
            step();
        end
        settle();
        n_vec++; if (div_busy !== 1'b0) begin n_err++; $display("FAIL div_done_busy got %b exp 0", div_busy); end
        n_vec++; if (issue !== 1'b1) begin n_err++; $display("FAIL div_add_issue got %b exp 1", issue); end
        step();
        idle_inputs();
        n_vec++; if (stall_count !== 32'd8) begin n_err++; $display("FAIL div_stall_count got %0d exp 8", stall_count); end
        n_vec++; if (pending !== 32'h180) begin n_err++; $display("FAIL div_pend78 got %h exp %h", pending, 32'h180); end
    endtask

    task automatic test_waw();
        drive(5'd0, 0, 5'd0, 0, 5'd8, 1, 0);
        settle();
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL waw_stall got %b exp 1", stall); end
        step();
        wb_valid = 1; wb_rd = 5'd8;
        settle();
        n_vec++; if (issue !== 1'b1) begin n_err++; $display("FAIL waw_wb_issue got %b exp 1", issue); end
        step();
        idle_inputs();
        n_vec++; if (pending !== 32'h180) begin n_err++; $display("FAIL waw_pending got %h exp %h", pending, 32'h180); end
        n_vec++; if (stall_count !== 32'd9) begin n_err++; $display("FAIL waw_stall_count got %0d exp 9", stall_count); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
        settle();
        n_vec++; if (issue !== 1'b1) begin n_err++; $display("FAIL flush_addi_issue got %b exp 1", issue); end
        step();
        n_vec++; if (pending !== 32'h200) begin n_err++; $display("FAIL flush_pend9 got %h exp %h", pending, 32'h200); end
        drive(5'd0, 0, 5'd0, 0, 5'd11, 1, 0);
        branch_taken = 1;
        settle();
        n_vec++; if (flush !== 1'b1 || issue !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL flush_outs got flush=%b issue=%b stall=%b exp 1 0 0", flush, issue, stall); end
        step();
        idle_inputs();
        settle();
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL flush_cleared got %h exp 0", pending); end
        n_vec++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL flush_no_stall got %0d exp 0", stall_count); end
    endtask

    task automatic test_div_flush();
        drive(5'd0, 0, 5'd0, 0, 5'd10, 1, 1);
        settle();
        n_vec++; if (issue !== 1'b1) begin n_err++; $display("FAIL dflush_issue got %b exp 1", issue); end
        step();
        idle_inputs();
        branch_taken = 1;
        settle();
        n_vec++; if (div_busy !== 1'b1 || flush !== 1'b1) begin n_err++; $display("FAIL dflush_busy got busy=%b flush=%b exp 1 1", div_busy, flush); end
        step();
        idle_inputs();
        settle();
        n_vec++; if (div_busy !== 1'b0) begin n_err++; $display("FAIL dflush_drop got %b exp 0", div_busy); end
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL dflush_pending got %h exp 0", pending); end
        drive(5'd0, 0, 5'd0, 0, 5'd12, 1, 0);
        settle();
        n_vec++; if (issue !== 1'b1) begin n_err++; $display("FAIL dflush_next_issue got %b exp 1", issue); end
        step();
        idle_inputs();
        n_vec++; if (pending !== 32'h1000 || div_busy !== 1'b0) begin n_err++; $display("FAIL dflush_after got pend=%h busy=%b exp 1000 0", pending, div_busy); end
    endtask

    task automatic test_x0_and_same_cycle();
        do_reset();
        drive(5'd0, 1, 5'd0, 1, 5'd0, 1, 0);
        settle();
        n_vec++; if (issue !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL x0_issue got issue=%b stall=%b exp 1 0", issue, stall); end
        step();
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL x0_pending got %h exp 0", pending); end
        drive(5'd0, 0, 5'd0, 0, 5'd3, 1, 0);
        step();
        n_vec++; if (pending !== 32'h8) begin n_err++; $display("FAIL same_set3 got %h exp 8", pending); end
        wb_valid = 1; wb_rd = 5'd3;
        settle();
        n_vec++; if (issue !== 1'b1) begin n_err++; $display("FAIL same_wb_issue got %b exp 1", issue); end
        step();
        idle_inputs();
        n_vec++; if (pending !== 32'h8) begin n_err++; $display("FAIL same_set_wins got %h exp 8", pending); end
        wb_valid = 1; wb_rd = 5'd0;
        step();
        n_vec++; if (pending !== 32'h8) begin n_err++; $display("FAIL wb_x0 got %h exp 8", pending); end
        wb_rd = 5'd20;
        step();
        idle_inputs();
        n_vec++; if (pending !== 32'h8) begin n_err++; $display("FAIL wb_not_pending got %h exp 8", pending); end
        drive(5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
        wb_valid = 1; wb_rd = 5'd3;
        settle();
        n_vec++; if (issue !== 1'b1) begin n_err++; $display("FAIL wbr_bypass_issue got %b exp 1", issue); end
        step();
        idle_inputs();
        n_vec++; if (pending !== 32'h10) begin n_err++; $display("FAIL wbr_pending got %h exp 10", pending); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
        step();
        drive(5'd0, 0, 5'd0, 0, 5'd10, 1, 1);
        settle();
        n_vec++; if (issue !== 1'b1) begin n_err++; $display("FAIL rmid_div_issue got %b exp 1", issue); end
        step();
        drive(5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
        settle();
        n_vec++; if (div_busy !== 1'b1 || pending !== 32'h420) begin n_err++; $display("FAIL rmid_state got busy=%b pend=%h exp 1 420", div_busy, pending); end
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rmid_stall got %b exp 1", stall); end
        step();
        n_vec++; if (stall_count !== 32'd1) begin n_err++; $display("FAIL rmid_count got %0d exp 1", stall_count); end
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        settle();
        n_vec++; if (pending !== 32'h0 || div_busy !== 1'b0) begin n_err++; $display("FAIL rmid_regs got pend=%h busy=%b exp 0 0", pending, div_busy); end
        n_vec++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL rmid_count0 got %0d exp 0", stall_count); end
        n_vec++; if (issue !== 1'b0 || stall !== 1'b0 || flush !== 1'b0) begin n_err++; $display("FAIL rmid_comb got %b%b%b exp 000", issue, stall, flush); end
        step();
        n_vec++; if (div_busy !== 1'b0) begin n_err++; $display("FAIL rmid_stays_idle got %b exp 0", div_busy); end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_raw();
        test_div_struct();
        test_waw();
        test_flush();
        test_div_flush();
        test_x0_and_same_cycle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
